// File: rtl/button_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// button_event_arbiter_if
// Event channel between the button arbiter and its consumer.
//
// Parameter:
//   ID_W        width of evt_id
// Signals:
//   evt_valid   an event is presented (driven by master)
//   evt_ready   consumer accepts the event this cycle (driven by slave)
//   evt_id      index of the button that caused the event
//   evt_release 0 = press event, 1 = release event
// Modports:
//   master      event producer (the arbiter)
//   slave       event consumer
// ---------------------------------------------------------------------------
interface button_event_arbiter_if #(
  parameter int ID_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic            evt_release;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_release,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_release,
    output evt_ready
  );
endinterface

// File: rtl/button_event_arbiter.sv
// ---------------------------------------------------------------------------
// button_event_arbiter
// Synchronizes and debounces up to N_BUTTONS raw push-button pins, turns each
// debounced press into a pending event, and serves pending events one at a
// time through a round-robin arbiter onto a valid/ready event channel.
//
// Optional feature macro: BUTTON_ARB_RELEASE_EVENT_EN
//   defined     -> debounced releases also become events (evt_release = 1)
//   undefined   -> release edges are ignored, evt_release is tied to 0
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   pressed   raw asynchronous button levels, 1 = pressed
//   evt       event channel (master side): evt_valid/evt_ready/evt_id/evt_release
//   db_level  debounced level per button
//   overrun   sticky per-button flag, set when an event had to be merged
// ---------------------------------------------------------------------------
module button_event_arbiter #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ID_W            = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_BUTTONS-1:0]          pressed,
  button_event_arbiter_if.master        evt,
  output logic [N_BUTTONS-1:0]          db_level,
  output logic [N_BUTTONS-1:0]          overrun
);

  localparam int             CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N_BUTTONS - 1);

  logic [N_BUTTONS-1:0] sync_meta;
  logic [N_BUTTONS-1:0] sync;
  logic [CNT_W-1:0]     db_cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] db_next;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] pend_press;
  logic [N_BUTTONS-1:0] grant_press;
  logic [N_BUTTONS-1:0] request;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      ptr_next;
  logic                 found;
  logic                 win_rel;
  logic                 load;
  logic                 valid_q;
  logic [ID_W-1:0]      id_q;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
  logic [N_BUTTONS-1:0] fall;
  logic [N_BUTTONS-1:0] pend_rel;
  logic [N_BUTTONS-1:0] grant_rel;
  logic                 rel_q;
`endif

  // Two-flop synchronizer on every raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= pressed;
      sync      <= sync;
      sync      <= sync_meta;
    end
  end

  // A new level is accepted on the cycle its counter has already seen
  // DEBOUNCE_CYCLES-1 consecutive disagreeing samples.
  always_comb begin
    db_next = db_level;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if ((sync[i] != db_level[i]) && (db_cnt[i] == CNT_MAX)) begin
        db_next[i] = sync[i];
      end
    end
  end

  assign rise = db_next & ~db_level;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
  assign fall = ~db_next & db_level;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_level <= db_next;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if ((sync[i] == db_level[i]) || (db_cnt[i] == CNT_MAX)) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A button with any pending bit is a single requester.
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
  assign request = pend_press | pend_rel;
`else
  assign request = pend_press;
`endif

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_BUTTONS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BUTTONS) begin
        idx = idx - N_BUTTONS;
      end
      cand = ID_W'(idx);
      if (!found && request[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign ptr_next = (winner == ID_LAST) ? '0 : winner + ID_W'(1);
  assign load     = ~valid_q | evt.evt_ready;

  // Press is always served before release for the same button, so a
  // button's events leave in the order they were debounced.
  always_comb begin
    grant_press = '0;
    win_rel     = 1'b0;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
    grant_rel   = '0;
`endif
    if (load && found) begin
      if (pend_press[winner]) begin
        grant_press[winner] = 1'b1;
      end else begin
        win_rel = 1'b1;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
        grant_rel[winner] = 1'b1;
`endif
      end
    end
  end

  // An edge arriving while the same kind of event is still pending and not
  // being granted merges into it and is flagged as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_press <= '0;
      overrun    <= '0;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
      pend_rel   <= '0;
`endif
    end else begin
      pend_press <= (pend_press & ~grant_press) | rise;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
      pend_rel   <= (pend_rel & ~grant_rel) | fall;
      overrun    <= overrun | (rise & pend_press & ~grant_press)
                            | (fall & pend_rel & ~grant_rel);
`else
      overrun    <= overrun | (rise & pend_press & ~grant_press);
`endif
    end
  end

  // One-entry output register; id/release hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      rr_ptr  <= '0;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
      rel_q   <= 1'b0;
`endif
    end else if (load) begin
      valid_q <= found;
      if (found) begin
        id_q   <= winner;
        rr_ptr <= ptr_next;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
        rel_q  <= win_rel;
`endif
      end
    end
  end

  assign evt.evt_valid   = valid_q;
  assign evt.evt_id      = id_q;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
  assign evt.evt_release = rel_q;
`else
  assign evt.evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_button_event_arbiter
// Self-checking bench for button_event_arbiter (N_BUTTONS=4,
// DEBOUNCE_CYCLES=4). Expected events are queued when pins are driven and
// compared as the DUT hands them over. Release events are expected only when
// BUTTON_ARB_RELEASE_EVENT_EN is defined.
// ---------------------------------------------------------------------------
module tb_button_event_arbiter;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int IDW = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] pressed;
  logic [N-1:0] db_level;
  logic [N-1:0] overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           rel;
  } exp_t;

  exp_t exp_q[$];
  int   rel_cnt [N];

  typedef struct {
    logic [N-1:0] pins;
    int           hold;
    logic [N-1:0] db;
    int           n;
    logic [7:0]   ids;
  } vec_t;

  vec_t tbl [8];

  button_event_arbiter_if #(.ID_W(IDW)) bus ();

  button_event_arbiter #(
    .N_BUTTONS(N),
    .DEBOUNCE_CYCLES(DEB),
    .ID_W(IDW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pressed(pressed),
    .evt(bus),
    .db_level(db_level),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive a pin pattern for 'hold' cycles, capture db_level, then release.
  task automatic applyStimulus(input logic [N-1:0] pins, input int hold,
                               output logic [N-1:0] db_seen);
    pressed = pins;
    repeat (hold) @(negedge clk);
    db_seen = db_level;
    pressed = '0;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
    if (hold >= DEB) begin
      for (int i = 0; i < N; i++) begin
        if (pins[i]) rel_cnt[i]++;
      end
    end
`endif
  endtask

  // Handshake monitor: outputs and ready are stable between negedge and posedge.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (bus.evt_release && rel_cnt[bus.evt_id] > 0) begin
        rel_cnt[bus.evt_id]--;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: got id=%0d rel=%0b, expected none",
                 bus.evt_id, bus.evt_release);
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_id", 32'(bus.evt_id), 32'(e.id));
        checkOutput("event_release", 32'(bus.evt_release), 32'(e.rel));
      end
    end
  end

  initial begin
    logic [N-1:0] db_seen;
    int first;
    int total;

    clk           = 1'b0;
    rst_n         = 1'b0;
    pressed       = '0;
    bus.evt_ready = 1'b0;
    for (int i = 0; i < N; i++) rel_cnt[i] = 0;

    // pins, hold, expected db_level, event count, ids (first event in LSBs)
    tbl[0] = '{pins: 4'b0101, hold: 10, db: 4'b0101, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd0}};
    tbl[1] = '{pins: 4'b0101, hold: 10, db: 4'b0101, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd0}};
    tbl[2] = '{pins: 4'b0010, hold: 10, db: 4'b0010, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd1}};
    tbl[3] = '{pins: 4'b0001, hold: 3,  db: 4'b0000, n: 0, ids: 8'd0};
    tbl[4] = '{pins: 4'b1000, hold: 10, db: 4'b1000, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
    tbl[5] = '{pins: 4'b1111, hold: 10, db: 4'b1111, n: 4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[6] = '{pins: 4'b0110, hold: 10, db: 4'b0110, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
    tbl[7] = '{pins: 4'b0100, hold: 10, db: 4'b0100, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};

    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(bus.evt_valid), 0);
    checkOutput("reset_id", 32'(bus.evt_id), 0);
    checkOutput("reset_release", 32'(bus.evt_release), 0);
    checkOutput("reset_db_level", 32'(db_level), 0);
    checkOutput("reset_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Press latency: button 1 rises before edge 1, evt_valid after edge 7.
    bus.evt_ready = 1'b1;
    exp_q.push_back('{id: 2'd1, rel: 1'b0});
    pressed = 4'b0010;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (first == 0 && bus.evt_valid) first = c;
    end
    checkOutput("press_latency", 32'(first), 7);
    checkOutput("latency_db_level", 32'(db_level), 32'(4'b0010));
    pressed = '0;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
    rel_cnt[1]++;
`endif
    repeat (14) @(negedge clk);
    checkOutput("latency_drained", 32'(exp_q.size()), 0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors with continuous ready; pointer state carries across.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        exp_q.push_back('{id: tbl[v].ids[2*k +: 2], rel: 1'b0});
      end
      applyStimulus(tbl[v].pins, tbl[v].hold, db_seen);
      checkOutput($sformatf("vec%0d_db_level", v), 32'(db_seen), 32'(tbl[v].db));
      repeat (14) @(negedge clk);
      checkOutput($sformatf("vec%0d_drained", v), 32'(exp_q.size()), 0);
    end

    // Backpressure: id 3 held while button 3 is pressed twice more.
    bus.evt_ready = 1'b0;
    exp_q.push_back('{id: 2'd3, rel: 1'b0});
    pressed = 4'b1000;
    repeat (10) @(negedge clk);
    checkOutput("stall_valid", 32'(bus.evt_valid), 1);
    checkOutput("stall_id", 32'(bus.evt_id), 3);
    pressed = '0;
    repeat (10) @(negedge clk);
    pressed = 4'b1000;
    repeat (10) @(negedge clk);
    checkOutput("stall_overrun_second", 32'(overrun), 0);
    pressed = '0;
    repeat (10) @(negedge clk);
    pressed = 4'b1000;
    repeat (10) @(negedge clk);
    checkOutput("stall_overrun_third", 32'(overrun), 32'(4'b1000));
    checkOutput("stall_id_held", 32'(bus.evt_id), 3);
    checkOutput("stall_valid_held", 32'(bus.evt_valid), 1);
    exp_q.push_back('{id: 2'd3, rel: 1'b0});
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
    rel_cnt[3] += 2;
`endif
    bus.evt_ready = 1'b1;
    pressed = '0;
    repeat (16) @(negedge clk);
    checkOutput("stall_drained", 32'(exp_q.size()), 0);
    checkOutput("stall_valid_idle", 32'(bus.evt_valid), 0);

    // Asynchronous reset while an event is presented and button 2 debounces.
    bus.evt_ready = 1'b0;
    pressed = 4'b0010;
    repeat (10) @(negedge clk);
    checkOutput("prereset_valid", 32'(bus.evt_valid), 1);
    checkOutput("prereset_id", 32'(bus.evt_id), 1);
    pressed = 4'b0110;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(bus.evt_valid), 0);
    checkOutput("async_reset_id", 32'(bus.evt_id), 0);
    checkOutput("async_reset_db_level", 32'(db_level), 0);
    checkOutput("async_reset_overrun", 32'(overrun), 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) rel_cnt[i] = 0;
    pressed = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{id: 2'd2, rel: 1'b0});
    bus.evt_ready = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("held_through_reset_db", 32'(db_level), 32'(4'b0100));
    checkOutput("held_through_reset_drained", 32'(exp_q.size()), 0);
    pressed = '0;
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
    rel_cnt[2]++;
`endif
    repeat (14) @(negedge clk);
    checkOutput("after_reset_drained", 32'(exp_q.size()), 0);

    // Press then release of button 2: release event only with the macro.
    exp_q.push_back('{id: 2'd2, rel: 1'b0});
`ifdef BUTTON_ARB_RELEASE_EVENT_EN
    exp_q.push_back('{id: 2'd2, rel: 1'b1});
`endif
    pressed = 4'b0100;
    repeat (10) @(negedge clk);
    pressed = '0;
    repeat (14) @(negedge clk);
    checkOutput("press_release_drained", 32'(exp_q.size()), 0);
    checkOutput("press_release_db_level", 32'(db_level), 0);

    total = 0;
    for (int i = 0; i < N; i++) total += rel_cnt[i];
    checkOutput("release_events_seen", 32'(total), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: simulation exceeded time bound, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
